// File: rtl/diffusion_pkg.sv
// Sizing helpers shared by the diffusion engine's banked-RAM arbitration logic.
package diffusion_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Bank-select field width; never narrower than one bit.
  function automatic int unsigned bank_bits(input int unsigned num_banks);
    return (num_banks > 1) ? clog2(num_banks) : 1;
  endfunction

  // Port-index field width; never narrower than one bit.
  function automatic int unsigned port_bits(input int unsigned num_ports);
    return (num_ports > 1) ? clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/bank_conflict_arbiter_if.sv
// Port-side request bundle and bank-side issue bundle of the bank conflict arbiter.
interface bank_conflict_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned BANK_SHIFT = 11,
  parameter int unsigned CNT_WIDTH  = 32
);
  import diffusion_pkg::*;

  localparam int unsigned PIDX_W = port_bits(NUM_PORTS);

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_BANKS-1:0]            bank_en;
  logic [NUM_BANKS*BANK_SHIFT-1:0] bank_addr;
  logic [NUM_BANKS*PIDX_W-1:0]     bank_port;
  logic                            conflict;
  logic [CNT_WIDTH-1:0]            conflict_cnt;
  logic                            cnt_clr;

  modport master (
    output req_valid, req_addr, cnt_clr,
    input  req_ready, bank_en, bank_addr, bank_port, conflict, conflict_cnt
  );

  modport slave (
    input  req_valid, req_addr, cnt_clr,
    output req_ready, bank_en, bank_addr, bank_port, conflict, conflict_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Single-bank arbiter: grants the first requester at or after the pointer, wrapping.
// With RR_MODE=0 the pointer is pinned to 0, giving lowest-index-wins priority.
module rr_arbiter
  import diffusion_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter bit          RR_MODE = 1'b1,
  localparam int unsigned IDX_W  = port_bits(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             any_c;

  // Rotating scan starting at the pointer.
  always_comb begin
    int unsigned      slot;
    logic [IDX_W-1:0] idx;
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    slot        = 0;
    idx         = '0;
    for (int unsigned k = 0; k < N; k++) begin
      slot = 32'(ptr_q) + k;
      if (slot >= N) slot = slot - N;
      idx = IDX_W'(slot);
      if (!any_c && req[idx]) begin
        any_c        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

  // Pointer moves just past the winner; holds on an idle cycle.
  always_comb begin
    ptr_d = ptr_q;
    if (!RR_MODE) begin
      ptr_d = '0;
    end else if (any_c) begin
      ptr_d = (32'(grant_idx_c) == N - 1) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bank_conflict_arbiter.sv
// N-port, M-bank conflict detector: one grant per bank per cycle, registered
// bank-side enables/addresses/port ids, and a saturating conflict-cycle counter.
module bank_conflict_arbiter
  import diffusion_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned NUM_BANKS  = 4,
  parameter int unsigned BANK_SHIFT = 11,
  parameter bit          RR_MODE    = 1'b1,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bank_conflict_arbiter_if.slave bus
);

  localparam int unsigned BSEL_W = bank_bits(NUM_BANKS);
  localparam int unsigned PIDX_W = port_bits(NUM_PORTS);

  logic [ADDR_WIDTH-1:0] addr_c  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  cand_c  [NUM_BANKS];
  logic [NUM_PORTS-1:0]  grant_c [NUM_BANKS];
  logic [PIDX_W-1:0]     gidx_c  [NUM_BANKS];
  logic [NUM_PORTS-1:0]  req_ready_c;
  logic                  conflict_c;

  logic [NUM_BANKS-1:0]            bank_en_q,   bank_en_d;
  logic [NUM_BANKS*BANK_SHIFT-1:0] bank_addr_q, bank_addr_d;
  logic [NUM_BANKS*PIDX_W-1:0]     bank_port_q, bank_port_d;
  logic                            conflict_q,  conflict_d;
  logic [CNT_WIDTH-1:0]            conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      addr_c[p] = bus.req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Candidate matrix: bits above the bank field alias by truncation.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      cand_c[b] = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        cand_c[b][p] = bus.req_valid[p] &&
                       (addr_c[p][BANK_SHIFT +: BSEL_W] == BSEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rr_arbiter #(
      .N       (NUM_PORTS),
      .RR_MODE (RR_MODE)
    ) u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (cand_c[b]),
      .grant_c     (grant_c[b]),
      .grant_idx_c (gidx_c[b])
    );
  end

  // A port sits in exactly one bank's candidate set, so OR-ing grants is safe.
  always_comb begin
    req_ready_c = '0;
    conflict_c  = 1'b0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      req_ready_c = req_ready_c | grant_c[b];
      if ((cand_c[b] & (cand_c[b] - NUM_PORTS'(1))) != '0) conflict_c = 1'b1;
    end
    if (!rst_n) req_ready_c = '0;
  end

  // Winner payload capture; idle banks keep their last address and port id.
  always_comb begin
    bank_en_d      = '0;
    bank_addr_d    = bank_addr_q;
    bank_port_d    = bank_port_q;
    conflict_d     = conflict_c;
    conflict_cnt_d = conflict_cnt_q;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (|cand_c[b]) begin
        bank_en_d[b]                    = 1'b1;
        bank_port_d[b*PIDX_W +: PIDX_W] = gidx_c[b];
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
          if (grant_c[b][p]) begin
            bank_addr_d[b*BANK_SHIFT +: BANK_SHIFT] = addr_c[p][BANK_SHIFT-1:0];
          end
        end
      end
    end
    if (bus.cnt_clr) begin
      conflict_cnt_d = '0;
    end else if (conflict_c && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_en_q      <= '0;
      bank_addr_q    <= '0;
      bank_port_q    <= '0;
      conflict_q     <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      bank_en_q      <= bank_en_d;
      bank_addr_q    <= bank_addr_d;
      bank_port_q    <= bank_port_d;
      conflict_q     <= conflict_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.bank_en      = bank_en_q;
  assign bus.bank_addr    = bank_addr_q;
  assign bus.bank_port    = bank_port_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_bank_conflict_arbiter.sv
// Bench for bank_conflict_arbiter: a round-robin and a fixed-priority build share one
// stimulus stream and are checked against an integer-level arbitration model.
module tb_bank_conflict_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned NP = 4;
  localparam int unsigned NB = 4;
  localparam int unsigned BS = 11;
  localparam int unsigned CW = 32;
  localparam int unsigned PB = 2;
  localparam logic [NB*BS-1:0] DIST_ADDR = {11'h7FF, 11'h001, 11'h245, 11'h123};
  localparam logic [NB*PB-1:0] DIST_PORT = 8'hE4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bank_conflict_arbiter_if #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .NUM_BANKS(NB),
                             .BANK_SHIFT(BS), .CNT_WIDTH(CW)) bus_rr ();
  bank_conflict_arbiter_if #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .NUM_BANKS(NB),
                             .BANK_SHIFT(BS), .CNT_WIDTH(CW)) bus_fp ();

  assign bus_fp.req_valid = bus_rr.req_valid;
  assign bus_fp.req_addr  = bus_rr.req_addr;
  assign bus_fp.cnt_clr   = bus_rr.cnt_clr;

  bank_conflict_arbiter #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_SHIFT(BS),
                          .RR_MODE(1'b1), .CNT_WIDTH(CW)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr));

  bank_conflict_arbiter #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .NUM_BANKS(NB), .BANK_SHIFT(BS),
                          .RR_MODE(1'b0), .CNT_WIDTH(CW)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp));

  int n_cmp = 0;
  int n_bad = 0;

  logic [NP-1:0] s_valid;
  logic [AW-1:0] s_addr [NP];
  logic          s_clr;

  int            rr_ptr [NB];
  logic [NP-1:0] exp_rdy_rr, exp_rdy_fp;
  logic [NB-1:0] exp_en_rr, exp_en_fp;
  logic [BS-1:0] exp_addr_rr [NB];
  logic [BS-1:0] exp_addr_fp [NB];
  int            exp_port_rr [NB];
  int            exp_port_fp [NB];
  logic          exp_conf;
  logic [CW-1:0] exp_cnt;

  function automatic int bank_of(input logic [AW-1:0] a);
    return (int'(a) / (1 << BS)) % NB;
  endfunction

  function automatic int ncand(input int b);
    int n = 0;
    for (int p = 0; p < NP; p++) if (s_valid[p] && bank_of(s_addr[p]) == b) n++;
    return n;
  endfunction

  // First requester of bank b scanning upward from the start port, wrapping.
  function automatic int winner(input int b, input bit use_rr);
    int start = use_rr ? rr_ptr[b] : 0;
    for (int k = 0; k < NP; k++) begin
      int p = (start + k) % NP;
      if (s_valid[p] && bank_of(s_addr[p]) == b) return p;
    end
    return -1;
  endfunction

  function automatic logic [NB*BS-1:0] pk_addr(input logic [BS-1:0] a [NB]);
    logic [NB*BS-1:0] r = '0;
    for (int b = 0; b < NB; b++) r[b*BS +: BS] = a[b];
    return r;
  endfunction

  function automatic logic [NB*PB-1:0] pk_port(input int pr [NB]);
    logic [NB*PB-1:0] r = '0;
    for (int b = 0; b < NB; b++) r[b*PB +: PB] = PB'(pr[b]);
    return r;
  endfunction

  task automatic drive();
    int w;
    bus_rr.req_valid = s_valid;
    for (int p = 0; p < NP; p++) bus_rr.req_addr[p*AW +: AW] = s_addr[p];
    bus_rr.cnt_clr = s_clr;
    #1;
    exp_rdy_rr = '0;
    exp_rdy_fp = '0;
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        w = winner(b, 1'b1);
        if (w >= 0) exp_rdy_rr[w] = 1'b1;
        w = winner(b, 1'b0);
        if (w >= 0) exp_rdy_fp[w] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    int   w;
    logic conf;
    conf = 1'b0;
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        rr_ptr[b] = 0; exp_addr_rr[b] = '0; exp_addr_fp[b] = '0;
        exp_port_rr[b] = 0; exp_port_fp[b] = 0;
      end
      exp_en_rr = '0; exp_en_fp = '0; exp_conf = 1'b0; exp_cnt = '0;
    end else begin
      for (int b = 0; b < NB; b++) if (ncand(b) >= 2) conf = 1'b1;
      for (int b = 0; b < NB; b++) begin
        w = winner(b, 1'b1);
        exp_en_rr[b] = (w >= 0);
        if (w >= 0) begin
          exp_addr_rr[b] = s_addr[w][BS-1:0]; exp_port_rr[b] = w; rr_ptr[b] = (w + 1) % NP;
        end
        w = winner(b, 1'b0);
        exp_en_fp[b] = (w >= 0);
        if (w >= 0) begin
          exp_addr_fp[b] = s_addr[w][BS-1:0]; exp_port_fp[b] = w;
        end
      end
      exp_conf = conf;
      if (s_clr) exp_cnt = '0;
      else if (conf && exp_cnt != '1) exp_cnt = exp_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_clr = 1'b0; s_valid = '1;
    for (int p = 0; p < NP; p++) s_addr[p] = 13'h0010;
    drive();
    n_cmp++; if (bus_rr.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b expected 0000", bus_rr.req_ready); end
    tick(); tick();
    n_cmp++; if (bus_rr.bank_en !== '0) begin n_bad++; $display("FAIL reset_bank_en: got %b expected 0", bus_rr.bank_en); end
    n_cmp++; if (bus_rr.bank_addr !== '0) begin n_bad++; $display("FAIL reset_bank_addr: got %h expected 0", bus_rr.bank_addr); end
    n_cmp++; if (bus_rr.bank_port !== '0) begin n_bad++; $display("FAIL reset_bank_port: got %h expected 0", bus_rr.bank_port); end
    n_cmp++; if (bus_rr.conflict !== 1'b0) begin n_bad++; $display("FAIL reset_conflict: got %b expected 0", bus_rr.conflict); end
    n_cmp++; if (bus_rr.conflict_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %h expected 0", bus_rr.conflict_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    s_valid = '1; s_clr = 1'b0;
    for (int p = 0; p < NP; p++) s_addr[p] = 13'h0010;
    for (int i = 0; i < NP; i++) begin
      drive();
      n_cmp++; if (bus_rr.req_ready !== (4'b0001 << i)) begin n_bad++; $display("FAIL cont_ready_rr[%0d]: got %b expected %b", i, bus_rr.req_ready, 4'b0001 << i); end
      n_cmp++; if (bus_fp.req_ready !== 4'b0001) begin n_bad++; $display("FAIL cont_ready_fp[%0d]: got %b expected 0001", i, bus_fp.req_ready); end
      tick();
      n_cmp++; if (bus_rr.conflict !== 1'b1) begin n_bad++; $display("FAIL cont_conflict[%0d]: got %b expected 1", i, bus_rr.conflict); end
      n_cmp++; if (bus_rr.bank_port[PB-1:0] !== PB'(i)) begin n_bad++; $display("FAIL cont_port_rr[%0d]: got %0d expected %0d", i, bus_rr.bank_port[PB-1:0], i); end
      n_cmp++; if (bus_rr.bank_addr[BS-1:0] !== 11'h010) begin n_bad++; $display("FAIL cont_addr_rr[%0d]: got %h expected 010", i, bus_rr.bank_addr[BS-1:0]); end
      n_cmp++; if (bus_fp.bank_en !== 4'b0001) begin n_bad++; $display("FAIL cont_en_fp[%0d]: got %b expected 0001", i, bus_fp.bank_en); end
    end
    n_cmp++; if (bus_rr.conflict_cnt !== 32'd4) begin n_bad++; $display("FAIL cont_cnt: got %0d expected 4", bus_rr.conflict_cnt); end
  endtask

  task automatic test_distinct();
    s_valid = 4'b1111;
    s_addr[0] = 13'h0123; s_addr[1] = 13'h0A45; s_addr[2] = 13'h1001; s_addr[3] = 13'h1FFF;
    drive();
    n_cmp++; if (bus_rr.req_ready !== 4'b1111) begin n_bad++; $display("FAIL dist_ready_rr: got %b expected 1111", bus_rr.req_ready); end
    n_cmp++; if (bus_fp.req_ready !== 4'b1111) begin n_bad++; $display("FAIL dist_ready_fp: got %b expected 1111", bus_fp.req_ready); end
    tick();
    n_cmp++; if (bus_rr.bank_en !== 4'b1111) begin n_bad++; $display("FAIL dist_en: got %b expected 1111", bus_rr.bank_en); end
    n_cmp++; if (bus_rr.conflict !== 1'b0) begin n_bad++; $display("FAIL dist_conflict: got %b expected 0", bus_rr.conflict); end
    n_cmp++; if (bus_rr.bank_port !== DIST_PORT) begin n_bad++; $display("FAIL dist_port: got %h expected %h", bus_rr.bank_port, DIST_PORT); end
    n_cmp++; if (bus_rr.bank_addr !== DIST_ADDR) begin n_bad++; $display("FAIL dist_addr: got %h expected %h", bus_rr.bank_addr, DIST_ADDR); end
    n_cmp++; if (bus_rr.conflict_cnt !== 32'd4) begin n_bad++; $display("FAIL dist_cnt: got %0d expected 4", bus_rr.conflict_cnt); end
  endtask

  task automatic test_idle();
    s_valid = '0;
    for (int p = 0; p < NP; p++) s_addr[p] = AW'($urandom_range(0, 8191));
    drive();
    n_cmp++; if (bus_rr.req_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_ready: got %b expected 0000", bus_rr.req_ready); end
    tick();
    n_cmp++; if (bus_rr.bank_en !== 4'b0000) begin n_bad++; $display("FAIL idle_en: got %b expected 0000", bus_rr.bank_en); end
    n_cmp++; if (bus_rr.bank_port !== DIST_PORT) begin n_bad++; $display("FAIL idle_port_hold: got %h expected %h", bus_rr.bank_port, DIST_PORT); end
    n_cmp++; if (bus_rr.bank_addr !== DIST_ADDR) begin n_bad++; $display("FAIL idle_addr_hold: got %h expected %h", bus_rr.bank_addr, DIST_ADDR); end
  endtask

  task automatic test_saturate();
    force dut_rr.conflict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut_rr.conflict_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    s_valid = 4'b0011; s_addr[0] = 13'h1000; s_addr[1] = 13'h1234;
    for (int i = 0; i < 3; i++) begin
      drive(); tick();
      n_cmp++; if (bus_rr.conflict_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_cnt[%0d]: got %h expected ffffffff", i, bus_rr.conflict_cnt); end
    end
    s_clr = 1'b1;
    drive(); tick();
    n_cmp++; if (bus_rr.conflict_cnt !== 32'd0) begin n_bad++; $display("FAIL clr_cnt: got %h expected 0", bus_rr.conflict_cnt); end
    n_cmp++; if (bus_rr.conflict !== 1'b1) begin n_bad++; $display("FAIL clr_conflict: got %b expected 1", bus_rr.conflict); end
    s_clr = 1'b0;
  endtask

  task automatic test_reset_midstream();
    s_valid = 4'b0010; s_addr[1] = 13'h0040;
    drive();
    n_cmp++; if (bus_rr.req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_pre_ready: got %b expected 0010", bus_rr.req_ready); end
    tick();
    rst_n = 1'b0; s_valid = 4'b1111;
    for (int p = 0; p < NP; p++) s_addr[p] = 13'h0077;
    drive();
    n_cmp++; if (bus_rr.req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 0000", bus_rr.req_ready); end
    tick();
    n_cmp++; if (bus_rr.bank_en !== '0 || bus_rr.bank_addr !== '0 || bus_rr.bank_port !== '0) begin
      n_bad++; $display("FAIL mid_rst_bank: got en=%b addr=%h port=%h expected all 0", bus_rr.bank_en, bus_rr.bank_addr, bus_rr.bank_port); end
    n_cmp++; if (bus_rr.conflict !== 1'b0 || bus_rr.conflict_cnt !== '0) begin
      n_bad++; $display("FAIL mid_rst_conf: got conflict=%b cnt=%h expected 0/0", bus_rr.conflict, bus_rr.conflict_cnt); end
    rst_n = 1'b1;
    drive();
    n_cmp++; if (bus_rr.req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_post_ready: got %b expected 0001", bus_rr.req_ready); end
    tick();
    n_cmp++; if (bus_rr.bank_port[PB-1:0] !== 2'd0 || bus_rr.bank_addr[BS-1:0] !== 11'h077) begin
      n_bad++; $display("FAIL mid_post_bank: got port=%0d addr=%h expected 0/077", bus_rr.bank_port[PB-1:0], bus_rr.bank_addr[BS-1:0]); end
  endtask

  task automatic test_fairness();
    int gap = 0;
    int max_gap = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = {1'b1, 3'($urandom)};
      for (int p = 0; p < NP; p++) s_addr[p] = AW'(13'h0800 | 13'($urandom_range(0, 2047)));
      drive();
      if (bus_rr.req_ready[3]) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
      tick();
    end
    n_cmp++; if (max_gap > NP - 1) begin n_bad++; $display("FAIL fairness_gap: got %0d expected <= %0d", max_gap, NP - 1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_n   = ($urandom_range(0, 63) != 0);
      s_clr   = ($urandom_range(0, 15) == 0);
      s_valid = NP'($urandom);
      for (int p = 0; p < NP; p++) s_addr[p] = AW'($urandom_range(0, 8191));
      drive();
      n_cmp++; if (bus_rr.req_ready !== exp_rdy_rr) begin n_bad++; $display("FAIL rand_ready_rr[%0d]: got %b expected %b", i, bus_rr.req_ready, exp_rdy_rr); end
      n_cmp++; if (bus_fp.req_ready !== exp_rdy_fp) begin n_bad++; $display("FAIL rand_ready_fp[%0d]: got %b expected %b", i, bus_fp.req_ready, exp_rdy_fp); end
      tick();
      n_cmp++; if (bus_rr.bank_en !== exp_en_rr) begin n_bad++; $display("FAIL rand_en_rr[%0d]: got %b expected %b", i, bus_rr.bank_en, exp_en_rr); end
      n_cmp++; if (bus_rr.bank_addr !== pk_addr(exp_addr_rr)) begin n_bad++; $display("FAIL rand_addr_rr[%0d]: got %h expected %h", i, bus_rr.bank_addr, pk_addr(exp_addr_rr)); end
      n_cmp++; if (bus_rr.bank_port !== pk_port(exp_port_rr)) begin n_bad++; $display("FAIL rand_port_rr[%0d]: got %h expected %h", i, bus_rr.bank_port, pk_port(exp_port_rr)); end
      n_cmp++; if (bus_rr.conflict !== exp_conf) begin n_bad++; $display("FAIL rand_conflict[%0d]: got %b expected %b", i, bus_rr.conflict, exp_conf); end
      n_cmp++; if (bus_rr.conflict_cnt !== exp_cnt) begin n_bad++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, bus_rr.conflict_cnt, exp_cnt); end
      n_cmp++; if (bus_fp.bank_en !== exp_en_fp) begin n_bad++; $display("FAIL rand_en_fp[%0d]: got %b expected %b", i, bus_fp.bank_en, exp_en_fp); end
      n_cmp++; if (bus_fp.bank_addr !== pk_addr(exp_addr_fp)) begin n_bad++; $display("FAIL rand_addr_fp[%0d]: got %h expected %h", i, bus_fp.bank_addr, pk_addr(exp_addr_fp)); end
      n_cmp++; if (bus_fp.bank_port !== pk_port(exp_port_fp)) begin n_bad++; $display("FAIL rand_port_fp[%0d]: got %h expected %h", i, bus_fp.bank_port, pk_port(exp_port_fp)); end
    end
    rst_n = 1'b1;
    s_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_distinct();
    test_idle();
    test_saturate();
    test_reset_midstream();
    test_fairness();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
